rx_fifo: RTL and testbench

RX_FIFO -- requirements
Module: rx_fifo

---
 rtl/ssp_pkg.sv | 13 +
 rtl/ssp_fifo_mem.sv | 19 +
 rtl/rx_fifo.sv | 73 +++++++
 tb/tb_rx_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Shared SSP FIFO sizing, used by both the receive and transmit FIFOs.
package ssp_pkg;
    localparam int SSP_DATA_W     = 8;
    localparam int SSP_FIFO_DEPTH = 4;
    localparam int SSP_PTR_W      = 2;
    localparam int SSP_CNT_W      = 3;

    typedef logic [SSP_DATA_W-1:0] ssp_word_t;
    typedef logic [SSP_PTR_W-1:0]  ssp_ptr_t;
    typedef logic [SSP_CNT_W-1:0]  ssp_cnt_t;

    localparam ssp_cnt_t SSP_CNT_FULL = ssp_cnt_t'(SSP_FIFO_DEPTH);
endpackage

// File: rtl/ssp_fifo_mem.sv
// SSP FIFO storage: synchronous write, asynchronous read, no reset on contents.
module ssp_fifo_mem
    import ssp_pkg::*;
(
    input  logic      clk,
    input  logic      we,
    input  ssp_ptr_t  waddr,
    input  ssp_word_t wdata,
    input  ssp_ptr_t  raddr,
    output ssp_word_t rdata
);
    ssp_word_t mem [SSP_FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rx_fifo.sv
// SSP receive FIFO: 4-deep first-word-fall-through buffer between the SSP
// receiver and the processor. Optional sticky OVERRUN with RX_OVERRUN_FLAG_EN.
module rx_fifo
    import ssp_pkg::*;
(
    input  logic      PCLK,
    input  logic      CLEAR,
    input  logic      PSEL,
    input  logic      PWRITE,
    output ssp_word_t PRDATA,
    input  ssp_word_t RxData,
    input  logic      RxValid,
    output logic      SSPRXINTR,
`ifdef RX_OVERRUN_FLAG_EN
    output logic      RxFull,
    output logic      OVERRUN
`else
    output logic      RxFull
`endif
);
    ssp_ptr_t  rd_ptr, wr_ptr;
    ssp_cnt_t  count;
    ssp_word_t rdata;
    logic      full, empty, pop_ok, push_ok;

    assign full  = (count == SSP_CNT_FULL);
    assign empty = (count == '0);

    // A pop at full frees the slot the simultaneous push lands in.
    assign pop_ok  = PSEL && !PWRITE && !empty;
    assign push_ok = RxValid && (!full || pop_ok);

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    ssp_fifo_mem u_mem (
        .clk   (PCLK),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (RxData),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Stale storage stays hidden whenever the FIFO is empty.
    assign PRDATA    = empty ? '0 : rdata;
    assign SSPRXINTR = full;
    assign RxFull    = full;

`ifdef RX_OVERRUN_FLAG_EN
    logic drop;
    assign drop = RxValid && full && !pop_ok;

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR)       OVERRUN <= 1'b0;
        else if (drop)   OVERRUN <= 1'b1;
        else if (pop_ok) OVERRUN <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_rx_fifo.sv
// Scoreboard bench for rx_fifo: pushed words queue up, pops compare PRDATA.
module tb_rx_fifo;
    logic       PCLK = 1'b0;
    logic       CLEAR, PSEL, PWRITE, RxValid;
    logic [7:0] RxData;
    logic [7:0] PRDATA;
    logic       SSPRXINTR, RxFull;
`ifdef RX_OVERRUN_FLAG_EN
    logic       OVERRUN;
    logic       exp_ovr;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];

    always #5 PCLK = ~PCLK;

    rx_fifo dut (
        .PCLK      (PCLK),
        .CLEAR     (CLEAR),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .PRDATA    (PRDATA),
        .RxData    (RxData),
        .RxValid   (RxValid),
        .SSPRXINTR (SSPRXINTR),
`ifdef RX_OVERRUN_FLAG_EN
        .RxFull    (RxFull),
        .OVERRUN   (OVERRUN)
`else
        .RxFull    (RxFull)
`endif
    );

    // One clock: drive, advance the model, compare the popped head before the edge.
    task automatic step(input bit push, input logic [7:0] d, input bit rd, input bit wr = 1'b0);
        bit pop_ok, push_ok;
        pop_ok  = rd && !wr && (sb.size() > 0);
        push_ok = push && (sb.size() < 4 || pop_ok);
        PSEL    = rd | wr;
        PWRITE  = wr;
        RxValid = push;
        RxData  = d;
        #1;
        if (pop_ok) begin
            checks++;
            if (PRDATA !== sb[0]) begin
                failures++;
                $display("FAIL pop_data got=%h exp=%h", PRDATA, sb[0]);
            end
            void'(sb.pop_front());
        end
        if (push_ok) sb.push_back(d);
`ifdef RX_OVERRUN_FLAG_EN
        if (push && !push_ok) exp_ovr = 1'b1;
        else if (pop_ok)      exp_ovr = 1'b0;
`endif
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PWRITE = 1'b0; RxValid = 1'b0; RxData = '0;
    endtask

    task automatic test_reset();
        CLEAR = 1'b1; PSEL = 1'b0; PWRITE = 1'b0; RxValid = 1'b0; RxData = '0;
        sb.delete();
`ifdef RX_OVERRUN_FLAG_EN
        exp_ovr = 1'b0;
`endif
        #3;
        checks++;
        if (PRDATA !== 8'h00 || RxFull !== 1'b0 || SSPRXINTR !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got=%h/%b/%b exp=00/0/0", PRDATA, RxFull, SSPRXINTR);
        end
`ifdef RX_OVERRUN_FLAG_EN
        checks++;
        if (OVERRUN !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", OVERRUN); end
`endif
        @(posedge PCLK); #3; CLEAR = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic fill4();
        logic [7:0] w [4];
        w = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, w[i], 1'b0);
            checks++;
            if (RxFull !== (i == 3) || SSPRXINTR !== (i == 3)) begin
                failures++;
                $display("FAIL fill_flag[%0d] got=%b/%b exp=%b", i, RxFull, SSPRXINTR, i == 3);
            end
            checks++;
            if (PRDATA !== 8'hA1) begin failures++; $display("FAIL fill_head[%0d] got=%h exp=a1", i, PRDATA); end
        end
    endtask

    task automatic drain_check_empty(input string tag);
        while (sb.size() > 0) step(1'b0, 8'h00, 1'b1);
        checks++;
        if (PRDATA !== 8'h00 || RxFull !== 1'b0) begin
            failures++;
            $display("FAIL %s_empty got=%h/%b exp=00/0", tag, PRDATA, RxFull);
        end
    endtask

    task automatic test_fill_drain();
        fill4();
        // A processor write must not pop.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (PRDATA !== 8'hA1 || RxFull !== 1'b1) begin
            failures++;
            $display("FAIL write_ignored got=%h/%b exp=a1/1", PRDATA, RxFull);
        end
        drain_check_empty("fill_drain");
    endtask

    task automatic test_overrun();
        fill4();
        step(1'b1, 8'hE5, 1'b0);
        checks++;
        if (PRDATA !== 8'hA1 || RxFull !== 1'b1) begin
            failures++;
            $display("FAIL ovr_hold got=%h/%b exp=a1/1", PRDATA, RxFull);
        end
`ifdef RX_OVERRUN_FLAG_EN
        checks++;
        if (OVERRUN !== exp_ovr) begin failures++; $display("FAIL ovr_set got=%b exp=%b", OVERRUN, exp_ovr); end
`endif
        step(1'b0, 8'h00, 1'b1);
`ifdef RX_OVERRUN_FLAG_EN
        checks++;
        if (OVERRUN !== exp_ovr) begin failures++; $display("FAIL ovr_clr got=%b exp=%b", OVERRUN, exp_ovr); end
`endif
        drain_check_empty("overrun");
    endtask

    task automatic test_full_simul();
        fill4();
        step(1'b1, 8'h55, 1'b1);
        checks++;
        if (PRDATA !== 8'hB2 || RxFull !== 1'b1 || SSPRXINTR !== 1'b1) begin
            failures++;
            $display("FAIL full_simul got=%h/%b/%b exp=b2/1/1", PRDATA, RxFull, SSPRXINTR);
        end
`ifdef RX_OVERRUN_FLAG_EN
        checks++;
        if (OVERRUN !== 1'b0) begin failures++; $display("FAIL full_simul_ovr got=%b exp=0", OVERRUN); end
`endif
        drain_check_empty("full_simul");
    endtask

    task automatic test_empty_simul();
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (PRDATA !== 8'h00 || RxFull !== 1'b0) begin
            failures++;
            $display("FAIL empty_pop got=%h/%b exp=00/0", PRDATA, RxFull);
        end
        step(1'b1, 8'h3C, 1'b1);
        checks++;
        if (PRDATA !== 8'h3C || RxFull !== 1'b0) begin
            failures++;
            $display("FAIL empty_simul got=%h/%b exp=3c/0", PRDATA, RxFull);
        end
        drain_check_empty("empty_simul");
    endtask

    task automatic test_wrap_reset();
        step(1'b1, 8'h00, 1'b0);
        for (int i = 1; i < 10; i++) step(1'b1, 8'(i), 1'b1);
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (sb.size() != 0 || PRDATA !== 8'h00) begin
            failures++;
            $display("FAIL wrap_end got=%h exp=00", PRDATA);
        end
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h88, 1'b0);
        checks++;
        if (PRDATA !== 8'h77) begin failures++; $display("FAIL pre_clear got=%h exp=77", PRDATA); end
        // Clear between edges with a push and pop still being driven.
        RxValid = 1'b1; RxData = 8'h99; PSEL = 1'b1; PWRITE = 1'b0;
        #2; CLEAR = 1'b1; #1;
        sb.delete();
        checks++;
        if (PRDATA !== 8'h00 || RxFull !== 1'b0 || SSPRXINTR !== 1'b0) begin
            failures++;
            $display("FAIL mid_clear got=%h/%b/%b exp=00/0/0", PRDATA, RxFull, SSPRXINTR);
        end
        RxValid = 1'b0; PSEL = 1'b0;
        @(posedge PCLK); #3; CLEAR = 1'b0;
        @(posedge PCLK); #1;
        step(1'b1, 8'h5A, 1'b0);
        checks++;
        if (PRDATA !== 8'h5A) begin failures++; $display("FAIL post_clear got=%h exp=5a", PRDATA); end
        drain_check_empty("wrap_reset");
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overrun();
        test_full_simul();
        test_empty_simul();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
